div_sequencer: RTL and testbench

Multi-cycle signed 32-bit divider controller for the processor's multdiv unit. It owns the AQ/M registers and iterates the non-restoring division step once per clock, for WIDTH cycles. It then applies remainder correction and sign fix-up, and returns the quotient with a one-cycle ready pulse. The pipeline stalls on it until ready is asserted.

---
 rtl/div_sequencer.sv | 77 +++++++
 tb/tb_div_sequencer.sv | 94 +++++++++
 2 files changed

// File: rtl/div_sequencer.sv
// div_sequencer: multi-cycle signed non-restoring divider with remainder correction and sign fix-up.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_div,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  state_t state, next;
  logic [CW-1:0] count;
  logic [WIDTH:0] a_q, m_q, a_shift, a_step, a_fix;
  logic [WIDTH-1:0] q_q, dvd_q, abs_a, abs_b, quot, rem;
  logic neg_q, neg_r, dz;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= next;
  always_comb
    next = ctrl_div ? RUN :
           state == RUN ? (count == CW'(WIDTH-1) ? FIX : RUN) :
           state == FIX ? DONE : IDLE;
  always_comb begin
    busy = state == RUN || state == FIX;
    data_resultRDY = state == DONE;
  end
  // 0x80000000 negates to itself and is then read as unsigned magnitude.
  always_comb begin
    abs_a = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    a_shift = {a_q[WIDTH-1:0], q_q[WIDTH-1]};
    a_step = a_q[WIDTH] ? a_shift + m_q : a_shift - m_q;
    a_fix = a_q[WIDTH] ? a_q + m_q : a_q;
    quot = dz ? '0 : neg_q ? -q_q : q_q;
    rem = dz ? dvd_q : neg_r ? -a_fix[WIDTH-1:0] : a_fix[WIDTH-1:0];
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      a_q <= '0;
      q_q <= '0;
      m_q <= '0;
      dvd_q <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz <= 1'b0;
      data_result <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_div) begin
      count <= '0;
      a_q <= '0;
      q_q <= abs_a;
      m_q <= {1'b0, abs_b};
      dvd_q <= data_operandA;
      neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      neg_r <= data_operandA[WIDTH-1];
      dz <= data_operandB == '0;
      data_exception <= 1'b0;
    end else if (state == RUN) begin
      count <= count + CW'(1);
      a_q <= a_step;
      q_q <= {q_q[WIDTH-2:0], ~a_step[WIDTH]};
    end else if (state == FIX) begin
      a_q <= a_fix;
      data_result <= quot;
      data_remainder <= rem;
      data_exception <= dz;
    end
endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: directed checks of latency, signed quadrants, boundaries, restart and async reset.
module tb_div_sequencer;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic ctrl_div = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] data_result, data_remainder;
  logic data_exception, data_resultRDY, busy;
  int compared = 0, mismatched = 0;
  div_sequencer #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .ctrl_div(ctrl_div),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_remainder(data_remainder),
    .data_exception(data_exception), .data_resultRDY(data_resultRDY), .busy(busy)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  // Called at a negedge; the following posedge is the start edge E0.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    ctrl_div = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_div = 1'b0;
  endtask
  // Counts negedges until ready; ready is due in the cycle after E33.
  task automatic wait_rdy(input string tag);
    int n = 0;
    while (n < 40 && !data_resultRDY) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_latency"}, n, 33);
  endtask
  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r, input logic e);
    start(a, b);
    chk({tag, "_busy"}, {31'b0, busy}, 1);
    wait_rdy(tag);
    chk({tag, "_result"}, data_result, q);
    chk({tag, "_rem"}, data_remainder, r);
    chk({tag, "_exc"}, {31'b0, data_exception}, {31'b0, e});
    @(negedge clock);
    chk({tag, "_rdy_pulse"}, {31'b0, data_resultRDY}, 0);
    chk({tag, "_hold"}, data_result, q);
  endtask
  initial begin
    #12;
    chk("reset_result", data_result, 0);
    chk("reset_rdy", {31'b0, data_resultRDY}, 0);
    chk("reset_busy", {31'b0, busy}, 0);
    reset_n = 1'b1;
    @(negedge clock);
    run("pos", 100, 7, 14, 2, 0);
    run("negA", -32'sd100, 7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);
    run("negB", 100, -32'sd7, 32'hFFFFFFF2, 2, 0);
    run("negAB", -32'sd100, -32'sd7, 14, 32'hFFFFFFFE, 0);
    run("dz", 5, 0, 0, 5, 1);
    run("after_dz", 9, 3, 3, 0, 0);
    run("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0, 0);
    run("min_by_1", 32'h80000000, 1, 32'h80000000, 0, 0);
    run("zero_dvd", 0, 9, 0, 0, 0);
    run("small", 7, 9, 0, 7, 0);
    start(50, 5);
    for (int i = 0; i < 9; i++) begin
      chk("restart_no_rdy", {31'b0, data_resultRDY}, 0);
      @(negedge clock);
    end
    run("restart", 81, 9, 9, 0, 0);
    start(100, 7);
    repeat (20) @(negedge clock);
    reset_n = 1'b0;
    #1;
    chk("arst_result", data_result, 0);
    chk("arst_rem", data_remainder, 0);
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_rdy", {31'b0, data_resultRDY}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      chk("arst_no_rdy", {31'b0, data_resultRDY}, 0);
    end
    run("post_reset", 21, 4, 5, 1, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
